// File: rtl/fp_norm_shift_pipe.sv
// Two-stage normalisation shifter (coarse x4 then fine 0..3) with valid/ready flow control.
// Define FP_NORM_SHIFT_RIGHT_EN to enable right shifts (in_dir=1) with sticky collection.
module fp_norm_shift_pipe #(
  parameter int W   = 26,
  parameter int SHW = 5
) (
  input  logic           CLK,
  input  logic           RSTn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_mant,
  input  logic [SHW-1:0] in_shift,
  input  logic           in_mode,
  input  logic           in_dir,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_mant,
  output logic [SHW-1:0] out_shift,
  output logic           out_zero,
  output logic           out_sticky
);

  if ((2 ** SHW) <= W) begin : g_bad_cfg
    $error("fp_norm_shift_pipe: 2**SHW must exceed W");
  end

  localparam logic [SHW-1:0] W_AMT = SHW'(W);
  localparam logic [W-1:0]   ONES  = {W{1'b1}};

  // Stage registers
  logic           s1_valid, s2_valid;
  logic [W-1:0]   s1_mant, s2_mant;
  logic [1:0]     s1_fine;
  logic [SHW-1:0] s1_shift, s2_shift;
  logic           s2_zero;

  // Flow control: stage 2 advances when empty or drained; stage 1 when it can pass on.
  logic s2_en, s1_load;
  assign s2_en    = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_en;
  assign in_ready = s1_load;

  // Shift amount selection and saturation
  logic [SHW-1:0] lzc, amt, sat_amt, coarse;
  logic           sat;

  // NOTE: every always_comb variable gets a default before any conditional update, so no latch is inferred.
  always_comb begin
    lzc = W_AMT;
    for (int i = 0; i < W; i++) begin
      if (in_mant[i]) lzc = SHW'(W - 1 - i);
    end
  end

  assign amt     = in_mode ? lzc : in_shift;
  assign sat     = (amt >= W_AMT);
  assign sat_amt = sat ? W_AMT : amt;
  assign coarse  = {amt[SHW-1:2], 2'b00};

  // Coarse shift
  logic [W-1:0] c_mant;

`ifdef FP_NORM_SHIFT_RIGHT_EN
  logic dir, c_sticky, s1_dir, s1_sticky, s2_sticky;
  assign dir = in_dir && !in_mode;

  always_comb begin
    c_mant   = in_mant << coarse;
    c_sticky = 1'b0;
    if (dir) begin
      c_mant   = in_mant >> coarse;
      c_sticky = |(in_mant & ~(ONES << coarse));
    end
    if (sat) begin
      c_mant   = '0;
      c_sticky = dir && (|in_mant);
    end
  end
`else
  logic unused_dir;
  assign unused_dir = in_dir;

  always_comb begin
    c_mant = in_mant << coarse;
    if (sat) c_mant = '0;
  end
`endif

  // Fine shift
  logic [W-1:0] f_mant;

`ifdef FP_NORM_SHIFT_RIGHT_EN
  logic f_sticky;
  always_comb begin
    f_mant   = s1_mant << s1_fine;
    f_sticky = s1_sticky;
    if (s1_dir) begin
      f_mant   = s1_mant >> s1_fine;
      f_sticky = s1_sticky || (|(s1_mant & ~(ONES << s1_fine)));
    end
  end
`else
  always_comb f_mant = s1_mant << s1_fine;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s1_valid <= 1'b0;
      // NOTE: data registers are reset too, because the outputs must read 0 after reset.
      s1_mant  <= '0;
      s1_fine  <= '0;
      s1_shift <= '0;
`ifdef FP_NORM_SHIFT_RIGHT_EN
      s1_dir    <= 1'b0;
      s1_sticky <= 1'b0;
`endif
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mant  <= c_mant;
        s1_fine  <= amt[1:0];
        s1_shift <= sat_amt;
`ifdef FP_NORM_SHIFT_RIGHT_EN
        s1_dir    <= dir;
        s1_sticky <= c_sticky;
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s2_valid <= 1'b0;
      s2_mant  <= '0;
      s2_shift <= '0;
      s2_zero  <= 1'b0;
`ifdef FP_NORM_SHIFT_RIGHT_EN
      s2_sticky <= 1'b0;
`endif
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mant  <= f_mant;
        s2_shift <= s1_shift;
        s2_zero  <= (f_mant == '0);
`ifdef FP_NORM_SHIFT_RIGHT_EN
        s2_sticky <= f_sticky;
`endif
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_mant  = s2_mant;
  assign out_shift = s2_shift;
  assign out_zero  = s2_zero;
`ifdef FP_NORM_SHIFT_RIGHT_EN
  assign out_sticky = s2_sticky;
`else
  assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fp_norm_shift_pipe.sv
// Self-checking bench for fp_norm_shift_pipe: directed cases plus a scoreboarded random stream.
module tb_fp_norm_shift_pipe;
  localparam int W   = 26;
  localparam int SHW = 5;

  logic           CLK, RSTn;
  logic           in_valid, in_ready, in_mode, in_dir;
  logic [W-1:0]   in_mant;
  logic [SHW-1:0] in_shift;
  logic           out_valid, out_ready, out_zero, out_sticky;
  logic [W-1:0]   out_mant;
  logic [SHW-1:0] out_shift;

  fp_norm_shift_pipe #(.W(W), .SHW(SHW)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_shift(in_shift), .in_mode(in_mode), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_shift(out_shift), .out_zero(out_zero), .out_sticky(out_sticky)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0]   mant;
    logic [SHW-1:0] shift;
    logic           zero;
    logic           sticky;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  logic           stalled_prev = 1'b0;
  logic [W-1:0]   held_mant;
  logic [SHW-1:0] held_shift;
  logic           held_zero, held_sticky;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: whole shift in one step, LZC by scan from the MSB.
  function automatic exp_t model(input logic [W-1:0] m, input logic [SHW-1:0] sh,
                                 input logic mode, input logic dir);
    exp_t e;
    int amt, n;
    logic found, right;
    n = W;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && m[i]) begin
        n = W - 1 - i;
        found = 1'b1;
      end
    end
    amt = mode ? n : int'(sh);
`ifdef FP_NORM_SHIFT_RIGHT_EN
    right = dir && !mode;
`else
    right = 1'b0 & dir;
`endif
    e.sticky = 1'b0;
    if (amt >= W) e.mant = '0;
    else if (right) e.mant = m >> amt;
    else e.mant = m << amt;
    if (right) begin
      for (int i = 0; i < W; i++) if (i < amt && m[i]) e.sticky = 1'b1;
    end
    e.shift = SHW'((amt >= W) ? W : amt);
    e.zero  = (e.mant == '0);
    return e;
  endfunction

  // One cycle: sample at negedge+1 (inputs settled, far from posedge), then advance to next negedge.
  task automatic tick(output logic acc);
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    if (stalled_prev) begin
      check("stable_mant", 32'(out_mant), 32'(held_mant));
      check("stable_shift", 32'(out_shift), 32'(held_shift));
      check("stable_zero", 32'(out_zero), 32'(held_zero));
      check("stable_sticky", 32'(out_sticky), 32'(held_sticky));
    end
    if (out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_mant", 32'(out_mant), 32'(e.mant));
        check("sb_shift", 32'(out_shift), 32'(e.shift));
        check("sb_zero", 32'(out_zero), 32'(e.zero));
        check("sb_sticky", 32'(out_sticky), 32'(e.sticky));
      end
    end
    if (acc) sb.push_back(model(in_mant, in_shift, in_mode, in_dir));
    stalled_prev = out_valid && !out_ready;
    held_mant = out_mant;
    held_shift = out_shift;
    held_zero = out_zero;
    held_sticky = out_sticky;
    @(negedge CLK);
  endtask

  task automatic drive(input logic [W-1:0] m, input logic [SHW-1:0] sh,
                       input logic mode, input logic dir);
    // NOTE: stimulus is driven with blocking assignments at the negedge, away from the sampling edge.
    in_mant  = m;
    in_shift = sh;
    in_mode  = mode;
    in_dir   = dir;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [W-1:0] m, input logic [SHW-1:0] sh,
                      input logic mode, input logic dir);
    logic acc;
    int budget;
    drive(m, sh, mode, dir);
    acc = 1'b0;
    budget = 0;
    while (!acc && budget < 20) begin
      tick(acc);
      budget++;
    end
    check("send_accepted", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    int budget;
    in_valid = 1'b0;
    budget = 0;
    while ((sb.size() > 0 || out_valid) && budget < 50) begin
      tick(acc);
      budget++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic directed(input string tag, input logic [W-1:0] m, input logic [SHW-1:0] sh,
                          input logic mode, input logic dir,
                          input logic [W-1:0] em, input logic [SHW-1:0] es,
                          input logic ez, input logic est);
    logic acc;
    send(m, sh, mode, dir);
    check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
    tick(acc);
    check({tag, "_lat2_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_mant"}, 32'(out_mant), 32'(em));
    check({tag, "_shift"}, 32'(out_shift), 32'(es));
    check({tag, "_zero"}, 32'(out_zero), 32'(ez));
    check({tag, "_sticky"}, 32'(out_sticky), 32'(est));
    tick(acc);
  endtask

  typedef struct {
    logic [W-1:0]   mant;
    logic [SHW-1:0] shift;
    logic           mode;
    logic           dir;
  } beat_t;

  initial begin
    logic acc;
    int sent, budget;
    beat_t bp[4];

    RSTn = 1'b0;
    in_valid = 1'b0;
    in_mant = '0;
    in_shift = '0;
    in_mode = 1'b0;
    in_dir = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_mant", 32'(out_mant), 32'd0);
    check("rst_out_shift", 32'(out_shift), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    check("rst_out_sticky", 32'(out_sticky), 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);

    directed("explicit8", 26'h0001234, 5'd8, 1'b0, 1'b0, 26'h0123400, 5'd8, 1'b0, 1'b0);
    directed("auto_one", 26'h0000001, 5'd0, 1'b1, 1'b1, 26'h2000000, 5'd25, 1'b0, 1'b0);
    directed("auto_zero", 26'h0000000, 5'd3, 1'b1, 1'b0, 26'h0000000, 5'd26, 1'b1, 1'b0);
    directed("auto_msb", 26'h2345678, 5'd9, 1'b1, 1'b0, 26'h2345678, 5'd0, 1'b0, 1'b0);
    directed("sat31", 26'h3FFFFFF, 5'd31, 1'b0, 1'b0, 26'h0000000, 5'd26, 1'b1, 1'b0);
    directed("sat26", 26'h0000001, 5'd26, 1'b0, 1'b0, 26'h0000000, 5'd26, 1'b1, 1'b0);
    directed("left25", 26'h0000003, 5'd25, 1'b0, 1'b0, 26'h2000000, 5'd25, 1'b0, 1'b0);
`ifdef FP_NORM_SHIFT_RIGHT_EN
    directed("right4", 26'h0000013, 5'd4, 1'b0, 1'b1, 26'h0000001, 5'd4, 1'b0, 1'b1);
    directed("right7", 26'h0000080, 5'd7, 1'b0, 1'b1, 26'h0000001, 5'd7, 1'b0, 1'b0);
    directed("right_sat", 26'h0000010, 5'd30, 1'b0, 1'b1, 26'h0000000, 5'd26, 1'b1, 1'b1);
`else
    directed("right4", 26'h0000013, 5'd4, 1'b0, 1'b1, 26'h0000130, 5'd4, 1'b0, 1'b0);
`endif

    // Backpressure: four back-to-back beats against a stalled sink.
    bp[0] = '{26'h0000ABC, 5'd3, 1'b0, 1'b0};
    bp[1] = '{26'h0000100, 5'd0, 1'b1, 1'b0};
    bp[2] = '{26'h1234567, 5'd5, 1'b0, 1'b1};
    bp[3] = '{26'h0000007, 5'd22, 1'b0, 1'b0};
    out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 4; c++) begin
      drive(bp[sent].mant, bp[sent].shift, bp[sent].mode, bp[sent].dir);
      tick(acc);
      if (acc) sent++;
    end
    check("bp_accepted", 32'(sent), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    budget = 0;
    while (sent < 4 && budget < 20) begin
      drive(bp[sent].mant, bp[sent].shift, bp[sent].mode, bp[sent].dir);
      tick(acc);
      if (acc) sent++;
      budget++;
    end
    check("bp_all_sent", 32'(sent), 32'd4);
    drain();

    // Full throughput: one accept per cycle with a ready sink.
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      drive(W'($urandom), SHW'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
      tick(acc);
      if (acc) sent++;
    end
    check("throughput", 32'(sent), 32'd6);
    drain();

    // Random stream with random sink stalls.
    sent = 0;
    budget = 0;
    while (sent < 40 && budget < 400) begin
      if (!in_valid || acc)
        drive(($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom),
              SHW'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick(acc);
      if (acc) sent++;
      budget++;
    end
    check("rand_sent", 32'(sent), 32'd40);
    out_ready = 1'b1;
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(26'h0000055, 5'd1, 1'b0, 1'b0);
    send(26'h00000AA, 5'd2, 1'b0, 1'b0);
    check("mid_out_valid_pre", 32'(out_valid), 32'd1);
    RSTn = 1'b0;
    #1;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    check("mid_out_mant", 32'(out_mant), 32'd0);
    sb.delete();
    stalled_prev = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    RSTn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(acc);
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    directed("post_rst", 26'h0000F00, 5'd12, 1'b0, 1'b0, 26'h0F00000, 5'd12, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
